// File: rtl/pe_dot_sequencer_if.sv
// Signal bundle between the dot-product sequencer, its upstream term source,
// the combinational PE it drives, and the downstream result consumer.
interface pe_dot_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 31
);
    logic              start;
    logic [ACC_W-1:0]  bias;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_act;
    logic [DATA_W-1:0] in_wgt;
    logic [DATA_W-1:0] pe_input1;
    logic [DATA_W-1:0] pe_input2;
    logic [ACC_W-1:0]  pe_initsum;
    logic [ACC_W-1:0]  pe_result;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              busy;

    // The sequencer is the slave; the environment around it is the master.
    modport slave (
        input  start, bias, in_valid, in_act, in_wgt, pe_result, out_ready,
        output in_ready, pe_input1, pe_input2, pe_initsum, out_valid, out_sum, busy
    );

    modport master (
        output start, bias, in_valid, in_act, in_wgt, pe_result, out_ready,
        input  in_ready, pe_input1, pe_input2, pe_initsum, out_valid, out_sum, busy
    );
endinterface

// File: rtl/pe_dot_sequencer.sv
// Sequences one combinational PE through an LEN-term dot product, feeding the
// PE result back as the next initsum and presenting the final sum on valid/ready.
module pe_dot_sequencer #(
    parameter int LEN    = 9,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 31
) (
    input logic               clk,
    input logic               rst,
    pe_dot_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LAST = LEN_W'(LEN - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;

    logic run;
    logic accept;

    assign run    = (state_q == RUN);
    assign accept = run & bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_sum_q <= out_sum_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_sum_d = out_sum_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.bias;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_d = bus.pe_result;
                    if (cnt_q == LAST) begin
                        out_sum_d = bus.pe_result;
                        cnt_d     = '0;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            DONE: begin
                // A start arriving with the output handshake restarts without an idle gap.
                if (bus.out_ready) begin
                    if (bus.start) begin
                        acc_d   = bus.bias;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = run;
    assign bus.pe_input1  = run ? bus.in_act : {DATA_W{1'b0}};
    assign bus.pe_input2  = run ? bus.in_wgt : {DATA_W{1'b0}};
    assign bus.pe_initsum = acc_q;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_sum    = out_sum_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/pe_dot_sequencer.md
Name: pe_dot_sequencer

Overview:
Drives one combinational PE (ports input1, input2, initsum, result) through an N-term dot product, one term per accepted input beat. It streams activation/weight pairs into the PE, feeds the PE result back as the next initsum, and presents the final 31-bit sum on a valid/ready output. It sits between the line-buffer/weight-fetch logic and the convolution output path: it is the sequencing side of the PE interface.

Parameters:
LEN, 9, number of terms per dot product (3x3 kernel); legal range 1..2**LEN_W-1
LEN_W, 4, width of term counter
DATA_W, 16, operand width (signed two's complement)
ACC_W, 31, accumulator/result width (matches PE result)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin new dot product; sampled in IDLE, or in DONE together with out_ready
bias  input  ACC_W  starting accumulator value, captured with start
in_valid  input  1  in_act/in_wgt valid
in_ready  output  1  sequencer accepts a term this cycle
in_act  input  DATA_W  activation term
in_wgt  input  DATA_W  weight term
pe_input1  output  DATA_W  to PE input1
pe_input2  output  DATA_W  to PE input2
pe_initsum  output  ACC_W  to PE initsum
pe_result  input  ACC_W  from PE result (combinational, same cycle)
out_valid  output  1  out_sum valid
out_ready  input  1  downstream accepts out_sum
out_sum  output  ACC_W  completed dot product
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Registers: state, acc[ACC_W], cnt[LEN_W], out_sum.
- Reset (rst high at edge): state=IDLE, acc=0, cnt=0, out_sum=0; hence in_ready=0, out_valid=0, busy=0. Overrides all other inputs, including mid-RUN and in DONE; partial sum discarded.
- IDLE: in_ready=0. start=1 -> acc<=bias, cnt<=0, state<=RUN. in_valid ignored.
- RUN: in_ready=1 combinationally. pe_input1=in_act, pe_input2=in_wgt, pe_initsum=acc. Accept = in_valid & in_ready. On accept: acc<=pe_result, cnt<=cnt+1. On accept with cnt==LEN-1: out_sum<=pe_result, cnt<=0, state<=DONE. No accept: hold all state. start ignored in RUN.
- DONE: out_valid=1, in_ready=0, out_sum stable until handshake. out_ready=1 and start=0 -> IDLE. out_ready=1 and start=1 -> acc<=bias, cnt<=0, RUN (back-to-back, no idle cycle). start without out_ready ignored.
- Outside RUN: pe_input1=0, pe_input2=0, pe_initsum=acc.
- Latency: start at edge k -> in_ready high in cycle after k. Last accept at edge m -> out_valid high in cycle after m. Minimum LEN+1 cycles start-to-out_valid at full rate. Throughput LEN+1 cycles/result with back-to-back start.
- Arithmetic: the sequencer does no arithmetic. pe_result is taken as an opaque ACC_W-bit value; wrap/overflow is entirely the PE's. Bench PE model: result = (sign-extended input1*input2 + initsum) mod 2**31.
- LEN=1: single accept goes RUN->DONE directly.
- out_valid never drops without out_ready (except rst).

Test Plan:
- LEN=9, bias=31'h5, start, nine pairs (16'h0002,16'h0008) with in_valid held high -> out_valid exactly 10 cycles after start edge, out_sum=31'h0000_0095, then IDLE.
- Same stimulus with in_valid high only every other cycle -> cnt advances only on accepts, out_sum=31'h95 after the 9th accept, no extra terms absorbed.
- Nine pairs (16'hffff,16'h0001), bias=0 -> out_sum=31'h7fff_fff7 (-9). Hold out_ready=0 for 5 cycles -> out_valid, out_sum stable, in_ready=0.
- rst pulsed after 4 accepts -> next cycle: in_ready=0, out_valid=0, busy=0. New start, bias=0, nine (1,1) pairs -> out_sum=31'h9.
- In DONE, drive out_ready=1 and start=1 with bias=31'h3fff_ffff -> RUN next cycle with no IDLE gap; nine (0,x) pairs -> out_sum=31'h3fff_ffff.
- LEN=1 instance: bias=2, pair (16'hfffc,16'h0000) -> out_valid one cycle after accept, out_sum=31'h2.
